// File: rtl/modulo_decodi.sv
// Extended-Hamming(8,4) decoder: single-error correction, double-error detection,
// one-cycle registered result and saturating error-statistics counters.
module modulo_decodi #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       datos_cod,
    input  logic             valid_in,
    input  logic             clr_cnt,
    output logic [3:0]       datos_out,
    output logic             valid_out,
    output logic             err_simple,
    output logic             err_doble,
    output logic [2:0]       sindrome,
    output logic [CNT_W-1:0] cnt_simple,
    output logic [CNT_W-1:0] cnt_doble
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    logic [2:0] w_syn;
    logic       w_par;
    logic       w_single;
    logic       w_double;
    logic [7:0] w_flip;
    logic [7:0] w_corr;

    always_comb begin
        w_syn[0] = datos_cod[1] ^ datos_cod[3] ^ datos_cod[5] ^ datos_cod[7];
        w_syn[1] = datos_cod[2] ^ datos_cod[3] ^ datos_cod[6] ^ datos_cod[7];
        w_syn[2] = datos_cod[4] ^ datos_cod[5] ^ datos_cod[6] ^ datos_cod[7];
        w_par    = ^datos_cod;
        w_single = w_par;
        w_double = !w_par && (w_syn != 3'd0);
        // With S=0 the flip lands on p0, which is never extracted, so the p0-error case needs no special handling.
        w_flip   = w_single ? (8'd1 << w_syn) : 8'd0;
        w_corr   = datos_cod ^ w_flip;
    end

    logic [3:0]       r_datos_p1;
    logic [2:0]       r_sin_p1;
    logic             r_vld_p1;
    logic             r_es_p1;
    logic             r_ed_p1;
    logic [CNT_W-1:0] r_cnt_s;
    logic [CNT_W-1:0] r_cnt_d;

    // Stage p0 -> p1: register decoded result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_datos_p1 <= 4'd0;
            r_sin_p1   <= 3'd0;
            r_vld_p1   <= 1'b0;
            r_es_p1    <= 1'b0;
            r_ed_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= valid_in;
            r_es_p1  <= valid_in & w_single;
            r_ed_p1  <= valid_in & w_double;
            if (valid_in) begin
                r_datos_p1 <= {w_corr[7], w_corr[6], w_corr[5], w_corr[3]};
                r_sin_p1   <= w_syn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_s <= '0;
            r_cnt_d <= '0;
        end else if (clr_cnt) begin
            r_cnt_s <= '0;
            r_cnt_d <= '0;
        end else if (valid_in) begin
            if (w_single) begin
                r_cnt_s <= sat_inc(r_cnt_s);
            end
            if (w_double) begin
                r_cnt_d <= sat_inc(r_cnt_d);
            end
        end
    end

    assign datos_out  = r_datos_p1;
    assign sindrome   = r_sin_p1;
    assign valid_out  = r_vld_p1;
    assign err_simple = r_es_p1;
    assign err_doble  = r_ed_p1;
    assign cnt_simple = r_cnt_s;
    assign cnt_doble  = r_cnt_d;

endmodule

// File: tb/tb_modulo_decodi.sv
// Randomized bench for modulo_decodi against a positional-XOR Hamming model,
// plus literal decode, reset and counter-saturation expectations.
module tb_modulo_decodi;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       datos_cod = 8'd0;
    logic             valid_in = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [3:0]       datos_out;
    logic             valid_out;
    logic             err_simple;
    logic             err_doble;
    logic [2:0]       sindrome;
    logic [CNT_W-1:0] cnt_simple;
    logic [CNT_W-1:0] cnt_doble;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    modulo_decodi #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .datos_cod(datos_cod), .valid_in(valid_in),
        .clr_cnt(clr_cnt), .datos_out(datos_out), .valid_out(valid_out),
        .err_simple(err_simple), .err_doble(err_doble), .sindrome(sindrome),
        .cnt_simple(cnt_simple), .cnt_doble(cnt_doble)
    );

    always #5 clk = ~clk;

    // Syndrome as XOR of the positions of all set bits 1..7
    function automatic logic [2:0] syn(input logic [7:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 1; i < 8; i++) if (w[i]) s ^= i[2:0];
        return s;
    endfunction

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] w;
        logic [2:0] s;
        w = 8'd0;
        w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
        s = syn(w);
        w[1] = s[0]; w[2] = s[1]; w[4] = s[2];
        w[0] = ^w;
        return w;
    endfunction

    logic [3:0] m_dat = 4'd0;
    logic [2:0] m_sin = 3'd0;
    logic       m_vld = 1'b0, m_es = 1'b0, m_ed = 1'b0;
    int         m_cs = 0, m_cd = 0;

    always @(posedge clk or posedge rst) begin
        logic [7:0] w;
        logic [2:0] s;
        logic       p;
        if (rst) begin
            m_dat = 4'd0; m_sin = 3'd0; m_vld = 1'b0; m_es = 1'b0; m_ed = 1'b0;
            m_cs = 0; m_cd = 0;
        end else begin
            s = syn(datos_cod);
            p = ^datos_cod;
            w = datos_cod;
            if (valid_in) begin
                if (p) w[s] = ~w[s];
                m_dat = {w[7], w[6], w[5], w[3]};
                m_sin = s;
                m_vld = 1'b1;
                m_es  = p;
                m_ed  = !p && (s != 3'd0);
            end else begin
                m_vld = 1'b0; m_es = 1'b0; m_ed = 1'b0;
            end
            if (clr_cnt) begin
                m_cs = 0; m_cd = 0;
            end else if (valid_in) begin
                if (m_es && m_cs < CMAX) m_cs++;
                if (m_ed && m_cd < CMAX) m_cd++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("datos_out",  32'(datos_out),  32'(m_dat));
            chk("sindrome",   32'(sindrome),   32'(m_sin));
            chk("valid_out",  32'(valid_out),  32'(m_vld));
            chk("err_simple", 32'(err_simple), 32'(m_es));
            chk("err_doble",  32'(err_doble),  32'(m_ed));
            chk("cnt_simple", 32'(cnt_simple), 32'(m_cs));
            chk("cnt_doble",  32'(cnt_doble),  32'(m_cd));
            chk("flags_excl", 32'(err_simple & err_doble), 32'd0);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        valid_in  = v;
        datos_cod = d;
        clr_cnt   = c;
    endtask

    task automatic lit(input string tag, input logic [7:0] d, input logic [3:0] ed,
                       input logic [2:0] es, input logic esim, input logic edob);
        drive(1'b1, d, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_dat"}, 32'(datos_out), 32'(ed));
        chk({tag, "_sin"}, 32'(sindrome), 32'(es));
        chk({tag, "_es"},  32'(err_simple), 32'(esim));
        chk({tag, "_ed"},  32'(err_doble), 32'(edob));
        chk({tag, "_vld"}, 32'(valid_out), 32'd1);
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        int a, b, k;
        w = enc(4'($urandom_range(0, 15)));
        k = $urandom_range(0, 2);
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        if (k >= 1) w[a] = ~w[a];
        if (k == 2) w[b] = ~w[b];
        return w;
    endfunction

    function automatic logic [7:0] single_word();
        logic [7:0] w;
        int a;
        w = enc(4'($urandom_range(0, 15)));
        a = $urandom_range(0, 7);
        w[a] = ~w[a];
        return w;
    endfunction

    initial begin
        #1 rst = 1'b1;
        #3;
        chk("rst_dat",  32'(datos_out), 32'd0);
        chk("rst_vld",  32'(valid_out), 32'd0);
        chk("rst_cnts", 32'(cnt_simple), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        chk("enc_model", 32'(enc(4'b0001)), 32'h0F);
        lit("clean0", 8'b0000_0000, 4'b0000, 3'b000, 1'b0, 1'b0);
        lit("clean1", 8'b0000_1111, 4'b0001, 3'b000, 1'b0, 1'b0);
        lit("double", 8'b1011_0010, 4'b1010, 3'b111, 1'b0, 1'b1);
        lit("sgl_b5", 8'b0010_1111, 4'b0001, 3'b101, 1'b1, 1'b0);
        lit("sgl_p0", 8'b0000_1110, 4'b0001, 3'b000, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 40) == 0));
        end

        // Mid-stream asynchronous reset
        drive(1'b1, 8'b0010_1111, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("amid_dat", 32'(datos_out), 32'd0);
        chk("amid_sin", 32'(sindrome), 32'd0);
        chk("amid_flg", 32'({valid_out, err_simple, err_doble}), 32'd0);
        chk("amid_cnt", 32'({cnt_simple, cnt_doble}), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b0;
        lit("post_rst", 8'b0010_1111, 4'b0001, 3'b101, 1'b1, 1'b0);

        for (int n = 0; n < CMAX + 4; n++) drive(1'b1, single_word(), 1'b0);
        @(posedge clk); #1;
        chk("sat_cnt", 32'(cnt_simple), 32'(CMAX));
        drive(1'b1, 8'b1011_0010, 1'b1);
        @(posedge clk); #1;
        chk("clr_s", 32'(cnt_simple), 32'd0);
        chk("clr_d", 32'(cnt_doble), 32'd0);

        drive(1'b0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/modulo_decodi.md
MODULO_DECODI -- requirements
Module: modulo_decodi

Interface
REQ-001 Parameter CNT_W, default 8, width of the error-statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 datos_cod  input  8  received extended-Hamming(8,4) codeword.
REQ-005 valid_in  input  1  datos_cod is sampled on a rising clk edge when high.
REQ-006 clr_cnt  input  1  synchronous clear of both error counters.
REQ-007 datos_out  output  4  decoded (corrected) data nibble.
REQ-008 valid_out  output  1  datos_out and the flags hold a new result.
REQ-009 err_simple  output  1  single-bit error detected and corrected.
REQ-010 err_doble  output  1  uncorrectable double-bit error detected.
REQ-011 sindrome  output  3  Hamming syndrome of the sampled word.
REQ-012 cnt_simple  output  CNT_W  saturating count of single errors.
REQ-013 cnt_doble  output  CNT_W  saturating count of double errors.

Function
REQ-014 Codeword bit mapping: datos_cod[0] is the overall parity bit p0; datos_cod[i] is Hamming position i for i=1..7; positions 1, 2 and 4 are p1, p2 and p4; positions 3, 5, 6 and 7 are d0, d1, d2 and d3.
REQ-015 Data extraction: datos_out = {pos7, pos6, pos5, pos3} of the corrected word.
REQ-016 Syndrome bits:
- s0 = XOR of positions 1, 3, 5, 7
- s1 = XOR of positions 2, 3, 6, 7
- s2 = XOR of positions 4, 5, 6, 7
- sindrome = {s2, s1, s0}
REQ-017 Overall parity P = XOR of all 8 bits of datos_cod.
REQ-018 Decode cases:
- S=0, P=0: no error; data passed through; both flags 0.
- S!=0, P=1: single error at position S; that bit is inverted before extraction; err_simple=1.
- S=0, P=1: single error in p0; data unchanged; err_simple=1.
- S!=0, P=0: double error; no correction; raw data bits output; err_doble=1.
REQ-019 err_simple and err_doble are never both 1.
REQ-020 Latency is exactly one clock. On the rising edge where valid_in=1, datos_out, sindrome, err_simple, err_doble and valid_out=1 are registered from that sample.
REQ-021 On an edge with valid_in=0:
- valid_out=0, err_simple=0 and err_doble=0.
- datos_out and sindrome hold their previous values.
REQ-022 On each valid sample with err_simple=1, cnt_simple increments by 1; on each with err_doble=1, cnt_doble increments by 1.
- Each counter saturates at 2^CNT_W-1 and does not wrap.
REQ-023 clr_cnt=1 clears both counters to 0 on that edge; clr_cnt takes priority over a simultaneous increment.
REQ-024 Back-to-back valid_in is supported with one result per cycle and no stall.

Reset
REQ-025 While rst=1, asynchronously and independent of clk:
- datos_out=0000, sindrome=000
- valid_out=0, err_simple=0, err_doble=0
- cnt_simple=0, cnt_doble=0
REQ-026 Reset asserted during operation discards any in-flight result. The first valid_in after reset is released produces a result one clock later.

Verification
REQ-027 Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clk edge.
REQ-028 Decode of clean and double-error words, one cycle after the valid sample:

| datos_cod | datos_out | sindrome | err_simple | err_doble | valid_out |
|---|---|---|---|---|---|
| 8'b0000_0000 | 0000 | 000 | 0 | 0 | 1 |
| 8'b0000_1111 | 0001 | 000 | 0 | 0 | 1 |
| 8'b1011_0010 | 1010 | 111 | 0 | 1 | 1 |

REQ-029 Single-error correction, one cycle after the valid sample:

| datos_cod | datos_out | sindrome | err_simple | err_doble |
|---|---|---|---|---|
| 8'b0010_1111 (bit 5 flipped) | 0001 | 101 | 1 | 0 |
| 8'b0000_1110 (p0 flipped) | 0001 | 000 | 1 | 0 |

REQ-030 Counters: apply 2^CNT_W+3 consecutive single-error words -> cnt_simple stops at 2^CNT_W-1. Then clr_cnt=1 together with one more error word -> both counters read 0 after that edge.
